// File: rtl/fir_pkg.sv
// Shared defaults and beat type for the FIR output-stream buffer.
package fir_pkg;

    localparam int unsigned FIR_DATA_WIDTH = 32;
    localparam int unsigned FIR_SM_DEPTH   = 8;

    typedef struct packed {
        logic                      tlast;
        logic [FIR_DATA_WIDTH-1:0] tdata;
    } fir_beat_t;

endpackage

// File: rtl/fir_len_chk.sv
// Input-side frame length checker: counts pushed beats per frame and flags a sticky
// error when tlast does not land exactly on data_length_i.
module fir_len_chk (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  logic        tlast_i,
    input  logic [31:0] data_length_i,
    input  logic        err_clr_i,
    output logic        len_err_o
);

    logic [31:0] beat_cnt_q, beat_cnt_d;
    logic        len_err_q, len_err_d;
    logic [31:0] beat_inc;
    logic        mismatch;

    always_comb begin
        beat_inc   = beat_cnt_q + 32'd1;
        mismatch   = 1'b0;
        beat_cnt_d = beat_cnt_q;
        if (push_i) begin
            if (tlast_i) begin
                mismatch   = (beat_inc != data_length_i);
                beat_cnt_d = 32'd0;
            end else begin
                mismatch   = (beat_inc == data_length_i);
                beat_cnt_d = beat_inc;
            end
        end
        // A zero length disables the check entirely.
        if (data_length_i == 32'd0) begin
            mismatch = 1'b0;
        end
        len_err_d = len_err_q;
        if (err_clr_i) begin
            len_err_d = 1'b0;
        end else if (mismatch) begin
            len_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_cnt_q <= 32'd0;
            len_err_q  <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    assign len_err_o = len_err_q;

endmodule

// File: rtl/fir_sm_fifo.sv
// FWFT stream buffer behind the FIR sm_* master; reports fill level and frame completion.
// Define FIR_SM_LEN_CHECK_EN to build the frame length checker.
module fir_sm_fifo
    import fir_pkg::*;
#(
    parameter int unsigned pDATA_WIDTH = FIR_DATA_WIDTH,
    parameter int unsigned DEPTH       = FIR_SM_DEPTH
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic                   m_tvalid,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   frame_done,
    input  logic [31:0]            data_length,
    input  logic                   err_clr,
    output logic                   len_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [pDATA_WIDTH:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 frame_done_q, frame_done_d;
    logic                 push, pop;

    // Ready depends only on registered occupancy, never on m_tready.
    assign s_tready = (level_q != LW'(DEPTH));
    assign m_tvalid = (level_q != LW'(0));
    assign m_tdata  = mem_q[rd_ptr_q][pDATA_WIDTH-1:0];
    assign m_tlast  = mem_q[rd_ptr_q][pDATA_WIDTH];
    assign level    = level_q;
    assign frame_done = frame_done_q;

    always_comb begin
        push     = s_tvalid && s_tready;
        pop      = m_tvalid && m_tready;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        frame_done_d = pop && m_tlast;
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
        end
    end

`ifdef FIR_SM_LEN_CHECK_EN
    fir_len_chk u_len_chk (
        .clk_i         (axis_clk),
        .rst_i         (axis_rst),
        .push_i        (push),
        .tlast_i       (s_tlast),
        .data_length_i (data_length),
        .err_clr_i     (err_clr),
        .len_err_o     (len_err)
    );
`else
    logic unused_len_cfg;
    assign unused_len_cfg = ^{data_length, err_clr};
    assign len_err        = 1'b0;
`endif

endmodule

// File: doc/fir_sm_fifo.md
# fir_sm_fifo

Output-side stream buffer placed directly downstream of the FIR engine's `sm_*` AXI-Stream master. It absorbs FIR result bursts in a small first-word-fall-through FIFO, so the FIR is never stalled by short consumer back-pressure. It forwards `tlast` unchanged and reports fill level and frame completion. Optionally, it checks that each frame's `tlast` falls exactly at the programmed data length.

## Interface
- `pDATA_WIDTH`, 32, sample width (matches FIR `sm_tdata`).
- `DEPTH`, 8, FIFO entries; power of two, ≥2.
- `axis_clk`  in  1  sole clock; all logic on rising edge.
- `axis_rst`  in  1  reset, synchronous and active-high.
- `s_tvalid`  in  1  from FIR `sm_tvalid`.
- `s_tdata`  in  pDATA_WIDTH  from FIR `sm_tdata`.
- `s_tlast`  in  1  from FIR `sm_tlast`.
- `s_tready`  out  1  to FIR `sm_tready`.
- `m_tvalid`  out  1  to consumer.
- `m_tdata`  out  pDATA_WIDTH  to consumer.
- `m_tlast`  out  1  to consumer.
- `m_tready`  in  1  from consumer.
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `frame_done`  out  1  one-cycle pulse after the `tlast` beat leaves on the `m_` side.
- `data_length`  in  32  expected beats per frame (FIR length register value).
- `err_clr`  in  1  clears `len_err`.
- `len_err`  out  1  sticky frame-length mismatch flag.

## Operation
- Storage: DEPTH × (pDATA_WIDTH+1) register array; the extra bit holds `tlast`. Write pointer `wr_ptr`, read pointer `rd_ptr`, both $clog2(DEPTH) bits wide, wrapping naturally at DEPTH. Occupancy counter `level`.
- Push = `s_tvalid && s_tready`; `s_tready = (level != DEPTH)`. `s_tready` is driven from registered state only and has no dependency on `m_tready`.
- Pop = `m_tvalid && m_tready`; `m_tvalid = (level != 0)`; `m_tdata`/`m_tlast` = entry at `rd_ptr` (FWFT, combinational read of the register array).
- Push and pop in the same cycle: both pointers advance and `level` is unchanged. When full, no push can occur. When empty, no pop can occur.
- Data in the FIFO never changes while `m_tvalid=1 && m_tready=0`, as AXI-Stream requires.
- `frame_done` is registered: it is high for exactly one cycle, in the cycle after a pop whose `m_tlast=1`.
- Length check (input side): counter `beat_cnt` counts pushes within the current frame.
  - On a push with `s_tlast=1`: if `beat_cnt+1 != data_length`, set `len_err`. Then `beat_cnt` is cleared.
  - On a push with `s_tlast=0` where `beat_cnt+1 == data_length`, set `len_err`. `beat_cnt` keeps counting.
  - `data_length == 0` disables the check.
- `err_clr` has priority over set in the same cycle.
- Reset: pointers, `level`, `beat_cnt`, `frame_done`, and `len_err` are cleared; FIFO contents are discarded. A frame in flight is lost and the next push starts a new frame.

## Timing
- Reset values: `s_tready=1`, `m_tvalid=0`, `m_tdata`=array entry 0 (don't-care), `m_tlast` don't-care, `level=0`, `frame_done=0`, `len_err=0`.
- Latency: a word pushed at edge N is presented with `m_tvalid=1` after edge N, i.e. in cycle N+1. Minimum fall-through is one cycle.
- Throughput: one beat per cycle sustained when `m_tready=1`.
- `s_tready` falls in the cycle after the push that makes `level=DEPTH`. It rises in the cycle after the first pop from full.
- `len_err` is set in the cycle following the offending push.

## Configuration
- `FIR_SM_LEN_CHECK_EN` defined: `beat_cnt` and the length-check logic are built as described above.
- Not defined: no counter is built, `len_err` is tied 0, and `data_length`/`err_clr` are ignored. Ports remain present so the top level is unchanged.

## Structure
- Shared package `fir_pkg` holds the default `pDATA_WIDTH`, the default FIFO depth constant, and a packed beat type {tlast, tdata}.
- One sub-module, `fir_len_chk`, holds `beat_cnt` and `len_err`. It is instantiated only under `FIR_SM_LEN_CHECK_EN`.
- Pointer and count logic stay in `fir_sm_fifo`.

## Test plan
- Fill/drain: push 8 words 1..8 with `m_tready=0` → `level=8`, `s_tready=0` on the following cycle; raise `m_tready` → output 1..8 in order and `level` returns to 0.
- Streaming: continuous push of 600 beats with `m_tready=1` → `m_tvalid` high from cycle 2 onward, output equals input, `level` ≤1 throughout.
- Simultaneous push/pop at `level=4` → `level` stays 4 and the pointers wrap correctly past entry 7.
- Frame: `data_length=600`, `tlast` on beat 600 → `m_tlast` on output beat 600, `frame_done` pulses once in the next cycle, `len_err=0`.
- Length error (macro on): `data_length=10`, `tlast` on beat 9 → `len_err=1`. Assert `err_clr` → `len_err=0`. With the macro off, the same stimulus leaves `len_err=0`.
- Reset mid-burst at `level=5` → next cycle `level=0`, `m_tvalid=0`, `s_tready=1`, `len_err=0`.
